// File: rtl/ld_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM encoding, header/word geometry and the word address helper.
package ld_pkg;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    START = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam int HDR_BYTES      = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_WORDS      = HDR_BYTES / BYTES_PER_WORD;

  // Word k of the image lives at base + 4k; range is guaranteed by the header check.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] k);
    return base + {k[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: a 2-bit byte index and a 32-bit shift register.
// word_o includes the byte being accepted, so it is the complete word whenever full_o is high.
module byte_packer
  import ld_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shreg_q, shreg_d;

  // Next shift-register contents and byte index
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (byte_valid_i) begin
      shreg_d = {byte_i, shreg_q[31:8]};
      idx_d   = idx_q + 2'd1;
    end else begin
      shreg_d = shreg_q;
      idx_d   = idx_q;
    end
  end

  // Packer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= 32'd0;
      idx_q   <= 2'd0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign word_o = {byte_i, shreg_q[31:8]};
  assign full_o = byte_valid_i && (idx_q == LAST_IDX);

endmodule

// File: rtl/boot_loader.sv
// Instruction-memory boot loader: parses an 8-byte header (entry, count), writes the
// program words to memory and keeps the core parked on INT until the image is in.
module boot_loader
  import ld_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384,
  parameter logic [31:0] RST_ENTRY = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] address,
  output logic [31:0] memIn,
  output logic        write,
  output logic        INT,
  output logic [31:0] entryPoint,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [0:0]  hdr_idx_q, hdr_idx_d;
  logic [31:0] entry_q, entry_d;
  logic [31:0] n_q, n_d;
  logic [31:0] k_q, k_d;
  logic [31:0] address_q, address_d;
  logic [31:0] mem_in_q, mem_in_d;
  logic [31:0] entry_point_q, entry_point_d;
  logic        in_ready_q, in_ready_d;
  logic        write_q, write_d;
  logic        int_q, int_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept_s;
  logic        pk_full_s;
  logic [31:0] pk_word_s;
  logic        hdr_last_s;
  logic        hdr_bad_s;

  assign accept_s   = in_valid && in_ready_q;
  assign hdr_last_s = (int'(hdr_idx_q) == HDR_WORDS - 1);
  // pk_word_s is the count word here; entry_q already holds the entry word.
  assign hdr_bad_s  = (entry_q[1:0] != 2'b00) || (pk_word_s == 32'd0) || (pk_word_s > MAX_W);

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (accept_s),
    .byte_i       (in_data),
    .word_o       (pk_word_s),
    .full_o       (pk_full_s)
  );

  // Next-state logic, word counter and registered output decode
  always_comb begin
    state_d       = state_q;
    hdr_idx_d     = hdr_idx_q;
    entry_d       = entry_q;
    n_d           = n_q;
    k_d           = k_q;
    mem_in_d      = mem_in_q;
    entry_point_d = entry_point_q;

    case (state_q)
      HDR: begin
        if (pk_full_s) begin
          if (!hdr_last_s) begin
            entry_d   = pk_word_s;
            hdr_idx_d = hdr_idx_q + 1'b1;
          end else begin
            hdr_idx_d = 1'b0;
            if (hdr_bad_s) begin
              state_d = ERR;
            end else begin
              n_d           = pk_word_s;
              entry_point_d = entry_q;
              state_d       = LOAD;
            end
          end
        end else begin
          state_d = HDR;
        end
      end
      LOAD: begin
        if (pk_full_s) begin
          mem_in_d = pk_word_s;
          state_d  = WRITE;
        end else begin
          state_d = LOAD;
        end
      end
      WRITE: begin
        k_d = k_q + 32'd1;
        if (k_d == n_q) begin
          state_d = START;
        end else begin
          state_d = LOAD;
        end
      end
      START:   state_d = DONE;
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase

    address_d  = word_addr(BASE, k_d);
    in_ready_d = (state_d == HDR) || (state_d == LOAD) || (state_d == ERR);
    write_d    = (state_d == WRITE);
    int_d      = (state_d != DONE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HDR;
      hdr_idx_q     <= 1'b0;
      entry_q       <= 32'd0;
      n_q           <= 32'd0;
      k_q           <= 32'd0;
      address_q     <= BASE;
      mem_in_q      <= 32'd0;
      entry_point_q <= RST_ENTRY;
      in_ready_q    <= 1'b0;
      write_q       <= 1'b0;
      int_q         <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_idx_q     <= hdr_idx_d;
      entry_q       <= entry_d;
      n_q           <= n_d;
      k_q           <= k_d;
      address_q     <= address_d;
      mem_in_q      <= mem_in_d;
      entry_point_q <= entry_point_d;
      in_ready_q    <= in_ready_d;
      write_q       <= write_d;
      int_q         <= int_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign address    = address_q;
  assign memIn      = mem_in_q;
  assign write      = write_q;
  assign INT        = int_q;
  assign entryPoint = entry_point_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: header parsing, word writes, error parking,
// mid-load reset and post-done behaviour, plus a tiny PC model fed by INT/entryPoint.
module tb_boot_loader;

  localparam int unsigned TB_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] address;
  logic [31:0] memIn;
  logic        write;
  logic        INT;
  logic [31:0] entryPoint;
  logic        done;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          t0 = 0;
  logic        gap = 1'b0;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  logic [31:0] pc = 32'd0;

  boot_loader #(.MAX_WORDS(TB_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .address    (address),
    .memIn      (memIn),
    .write      (write),
    .INT        (INT),
    .entryPoint (entryPoint),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core PC: pinned to entryPoint while INT is high, then sequential fetch
  always @(posedge clk) begin
    if (INT) pc <= entryPoint;
    else     pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory-port monitor: logs writes and checks they never overlap in_ready
  always @(negedge clk) begin
    if (!rst && write === 1'b1) begin
      check("wr_while_ready", {31'd0, in_ready}, 32'd0);
      check("wr_aligned", {30'd0, address[1:0]}, 32'd0);
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = address;
        wr_data[wr_cnt] = memIn;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check("byte_accepted", {31'd0, in_ready}, 32'd1);
    end else begin
      @(negedge clk);
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    wr_cnt = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_address", address, 32'h0);
    check("rst_memIn", memIn, 32'h0);
    check("rst_INT", {31'd0, INT}, 32'd1);
    check("rst_entry", entryPoint, 32'h0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    wr_cnt = 0;
    rst = 1'b0;
    @(negedge clk);
    check("t1_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // 1: two-word image at full rate
    send_byte(8'h10);
    t0 = cyc;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_word(32'd2);
    send_word(32'h0050_0093);
    send_word(32'h0010_0113);
    check("t1_w2_write", {31'd0, write}, 32'd1);
    check("t1_w2_addr", address, 32'h4);
    check("t1_w2_data", memIn, 32'h0010_0113);
    check("t1_w2_INT", {31'd0, INT}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_start_write", {31'd0, write}, 32'd0);
    check("t1_start_INT", {31'd0, INT}, 32'd1);
    check("t1_start_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t1_INT_low", {31'd0, INT}, 32'd0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_entry", entryPoint, 32'h10);
    check("t1_pc", pc, 32'h10);
    check("t1_load_time", 32'(cyc - t0 + 1), 32'd19);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd2);
    check("t1_wr0_addr", wr_addr[0], 32'h0);
    check("t1_wr0_data", wr_data[0], 32'h0050_0093);
    check("t1_wr1_addr", wr_addr[1], 32'h4);
    check("t1_wr1_data", wr_data[1], 32'h0010_0113);

    // 2: same image with in_valid toggling
    do_reset();
    gap = 1'b1;
    send_word(32'h10);
    send_word(32'd2);
    send_word(32'h0050_0093);
    send_word(32'h0010_0113);
    gap = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd2);
    check("t2_wr0_data", wr_data[0], 32'h0050_0093);
    check("t2_wr1_addr", wr_addr[1], 32'h4);
    check("t2_wr1_data", wr_data[1], 32'h0010_0113);

    // 3: misaligned entry point
    do_reset();
    send_word(32'h2);
    send_word(32'd1);
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_INT", {31'd0, INT}, 32'd1);
    check("t3_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 20; i++) send_byte(8'(i + 1));
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_err_sticky", {31'd0, err}, 32'd1);
    check("t3_done", {31'd0, done}, 32'd0);
    check("t3_entry", entryPoint, 32'h0);
    check("t3_wr_cnt", 32'(wr_cnt), 32'd0);

    // 4: count boundaries
    do_reset();
    send_word(32'h100);
    send_word(32'd0);
    check("t4_n0_err", {31'd0, err}, 32'd1);
    check("t4_n0_INT", {31'd0, INT}, 32'd1);
    do_reset();
    send_word(32'h100);
    send_word(32'(TB_MAX + 1));
    check("t4_nmax1_err", {31'd0, err}, 32'd1);
    check("t4_nmax1_wr", 32'(wr_cnt), 32'd0);
    do_reset();
    send_word(32'h0);
    send_word(32'(TB_MAX));
    check("t4_nmax_noerr", {31'd0, err}, 32'd0);
    for (int i = 0; i < int'(TB_MAX); i++) send_word(32'hA000_0000 + 32'(i));
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4_nmax_done", {31'd0, done}, 32'd1);
    check("t4_nmax_wr_cnt", 32'(wr_cnt), 32'(TB_MAX));
    check("t4_nmax_last_addr", wr_addr[TB_MAX - 1], 32'h1C);
    check("t4_nmax_last_data", wr_data[TB_MAX - 1], 32'hA000_0007);

    // 5: reset after 2 of 3 words, then reload
    do_reset();
    send_word(32'h20);
    send_word(32'd3);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    check("t5_w2_addr", address, 32'h4);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_pre_entry", entryPoint, 32'h20);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    check("t5_rst_write", {31'd0, write}, 32'd0);
    check("t5_rst_address", address, 32'h0);
    check("t5_rst_memIn", memIn, 32'h0);
    check("t5_rst_INT", {31'd0, INT}, 32'd1);
    check("t5_rst_entry", entryPoint, 32'h0);
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_err", {31'd0, err}, 32'd0);
    wr_cnt = 0;
    rst = 1'b0;
    @(negedge clk);
    send_word(32'h40);
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_entry", entryPoint, 32'h40);
    check("t5_pc", pc, 32'h40);
    check("t5_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t5_wr0_addr", wr_addr[0], 32'h0);
    check("t5_wr0_data", wr_data[0], 32'hDEAD_BEEF);

    // 6: bytes offered after done
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_ready", {31'd0, in_ready}, 32'd0);
      check("t6_write", {31'd0, write}, 32'd0);
      check("t6_INT", {31'd0, INT}, 32'd0);
    end
    in_valid = 1'b0;
    check("t6_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t6_pc_runs", pc, 32'h40 + 32'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
